// File: rtl/y86_regfile_pkg.sv
//------------------------------------------------------------------------------
// Module : y86_pkg
// Brief  : Shared Y86-64 constants: word width, register IDs, icodes.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  localparam int WORD_W = 64;

  localparam logic [3:0] RAX   = 4'h0;
  localparam logic [3:0] RCX   = 4'h1;
  localparam logic [3:0] RDX   = 4'h2;
  localparam logic [3:0] RBX   = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RBP   = 4'h5;
  localparam logic [3:0] RSI   = 4'h6;
  localparam logic [3:0] RDI   = 4'h7;
  localparam logic [3:0] R8    = 4'h8;
  localparam logic [3:0] R9    = 4'h9;
  localparam logic [3:0] R10   = 4'hA;
  localparam logic [3:0] R11   = 4'hB;
  localparam logic [3:0] R12   = 4'hC;
  localparam logic [3:0] R13   = 4'hD;
  localparam logic [3:0] R14   = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;

  function automatic logic id_valid(input logic [3:0] id, input int nreg);
    return int'(id) < nreg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/y86_regfile_rdport.sv
//------------------------------------------------------------------------------
// Module : y86_regfile_rdport
// Brief  : One combinational read port; non-register IDs read 0, optional
//          write-to-read forwarding (port M has priority over port E).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module y86_regfile_rdport
  import y86_pkg::*;
#(
  parameter int NREG   = 15,
  parameter bit BYPASS = 1'b0
) (
  input  logic [WORD_W-1:0] regs [NREG],
  input  logic [3:0]        sel,
  input  logic              wen,
  input  logic              rst,
  input  logic [3:0]        dstE,
  input  logic [WORD_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [WORD_W-1:0] valM,
  output logic [WORD_W-1:0] val
);

  logic [WORD_W-1:0] w_stored;

  assign w_stored = id_valid(sel, NREG) ? regs[sel] : '0;

  generate
    if (BYPASS) begin : g_bypass
      always_comb begin
        val = w_stored;
        if (wen && !rst) begin
          if (id_valid(dstM, NREG) && (sel == dstM)) begin
            val = valM;
          end else if (id_valid(dstE, NREG) && (sel == dstE)) begin
            val = valE;
          end
        end
      end
    end else begin : g_no_bypass
      logic w_unused;
      assign w_unused = &{1'b0, wen, rst, dstE, valE, dstM, valM};
      assign val      = w_stored;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/y86_regfile.sv
//------------------------------------------------------------------------------
// Module : y86_regfile
// Brief  : Y86-64 register file, 2 async read + 1 debug read, 2 sync writes.
//          Macro Y86_REGFILE_BYPASS_EN enables forwarding on valA/valB.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module y86_regfile
  import y86_pkg::*;
#(
  parameter int                NREG     = 15,
  parameter logic [WORD_W-1:0] RSP_INIT = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [WORD_W-1:0] valA,
  output logic [WORD_W-1:0] valB,
  input  logic [3:0]        dstE,
  input  logic [WORD_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [WORD_W-1:0] valM,
  input  logic              wen,
  input  logic [3:0]        dbgSel,
  output logic [WORD_W-1:0] dbgVal
);

`ifdef Y86_REGFILE_BYPASS_EN
  localparam bit c_bypass = 1'b1;
`else
  localparam bit c_bypass = 1'b0;
`endif

  logic [WORD_W-1:0] r_regs [NREG];

  // Port M is written last so it wins a same-register collision (popq %rsp).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == int'(RSP)) ? RSP_INIT : '0;
      end
    end else if (wen) begin
      if (id_valid(dstE, NREG)) r_regs[dstE] <= valE;
      if (id_valid(dstM, NREG)) r_regs[dstM] <= valM;
    end
  end

  y86_regfile_rdport #(.NREG(NREG), .BYPASS(c_bypass)) u_port_a (
    .regs (r_regs), .sel (srcA), .wen (wen), .rst (rst),
    .dstE (dstE), .valE (valE), .dstM (dstM), .valM (valM), .val (valA)
  );

  y86_regfile_rdport #(.NREG(NREG), .BYPASS(c_bypass)) u_port_b (
    .regs (r_regs), .sel (srcB), .wen (wen), .rst (rst),
    .dstE (dstE), .valE (valE), .dstM (dstM), .valM (valM), .val (valB)
  );

  y86_regfile_rdport #(.NREG(NREG), .BYPASS(1'b0)) u_port_dbg (
    .regs (r_regs), .sel (dbgSel), .wen (wen), .rst (rst),
    .dstE (dstE), .valE (valE), .dstM (dstM), .valM (valM), .val (dbgVal)
  );

endmodule

`default_nettype wire

// File: tb/tb_y86_regfile.sv
//------------------------------------------------------------------------------
// Module : tb_y86_regfile
// Brief  : Self-checking bench for y86_regfile with a register-state scoreboard.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_y86_regfile;
  import y86_pkg::*;

  localparam logic [63:0] c_rsp_init = 64'h200;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  srcA, srcB, dstE, dstM, dbgSel;
  logic [63:0] valA, valB, valE, valM, dbgVal;
  logic        wen;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  y86_regfile #(.NREG(15), .RSP_INIT(c_rsp_init)) dut (
    .clk (clk), .rst (rst),
    .srcA (srcA), .srcB (srcB), .valA (valA), .valB (valB),
    .dstE (dstE), .valE (valE), .dstM (dstM), .valM (valM),
    .wen (wen), .dbgSel (dbgSel), .dbgVal (dbgVal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen  = 1'b0;
    rst  = 1'b0;
    dstE = RNONE;
    dstM = RNONE;
    valE = '0;
    valM = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sbq.push_back('{id: 4'(i), val: (i == 4) ? c_rsp_init : 64'h0});
    end
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      dbgSel = e.id;
      #1;
      total++;
      if (dbgVal !== e.val) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h want %h", e.id, dbgVal, e.val);
      end
    end
    srcA = RNONE;
    #1;
    total++;
    if (valA !== 64'h0) begin
      bad++;
      $display("FAIL reset_valA_rnone: got %h want %h", valA, 64'h0);
    end
  endtask

  task automatic test_dual_write();
    logic [63:0] ea, eb;
    idle();
    srcA = RAX; srcB = RBX;
    dstE = RAX; valE = 64'h11;
    dstM = RBX; valM = 64'h22;
    wen  = 1'b1;
    #1;
`ifdef Y86_REGFILE_BYPASS_EN
    ea = 64'h11; eb = 64'h22;
`else
    ea = 64'h0;  eb = 64'h0;
`endif
    total++;
    if (valA !== ea) begin
      bad++;
      $display("FAIL dual_same_cycle_valA: got %h want %h", valA, ea);
    end
    total++;
    if (valB !== eb) begin
      bad++;
      $display("FAIL dual_same_cycle_valB: got %h want %h", valB, eb);
    end
    sbq.push_back('{id: RAX, val: 64'h11});
    sbq.push_back('{id: RBX, val: 64'h22});
    tick();
    idle();
    #1;
    total++;
    if (valA !== 64'h11) begin
      bad++;
      $display("FAIL dual_next_valA: got %h want %h", valA, 64'h11);
    end
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      dbgSel = e.id;
      #1;
      total++;
      if (dbgVal !== e.val) begin
        bad++;
        $display("FAIL dual_reg%0d: got %h want %h", e.id, dbgVal, e.val);
      end
    end
  endtask

  task automatic test_collision();
    idle();
    dstE = RSP; valE = 64'h1F8;
    dstM = RSP; valM = 64'hDEAD;
    wen  = 1'b1;
    sbq.push_back('{id: RSP, val: 64'hDEAD});
    tick();
    idle();
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      dbgSel = e.id;
      #1;
      total++;
      if (dbgVal !== e.val) begin
        bad++;
        $display("FAIL collision_reg%0d: got %h want %h", e.id, dbgVal, e.val);
      end
    end
  endtask

  task automatic test_suppress();
    idle();
    dstE = RDX; valE = 64'h5;
    tick();
    idle();
    wen  = 1'b1;
    dstE = RNONE; valE = 64'hBAD0;
    dstM = RNONE; valM = 64'hBAD1;
    tick();
    idle();
    for (int i = 0; i < 15; i++) begin
      logic [63:0] v;
      v = (i == 0) ? 64'h11 : (i == 3) ? 64'h22 : (i == 4) ? 64'hDEAD : 64'h0;
      sbq.push_back('{id: 4'(i), val: v});
    end
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      dbgSel = e.id;
      #1;
      total++;
      if (dbgVal !== e.val) begin
        bad++;
        $display("FAIL suppress_reg%0d: got %h want %h", e.id, dbgVal, e.val);
      end
    end
  endtask

  task automatic test_reset_over_write();
    idle();
    wen = 1'b1; dstE = RCX; valE = 64'h33;
    tick();
    idle();
    dbgSel = RCX;
    #1;
    total++;
    if (dbgVal !== 64'h33) begin
      bad++;
      $display("FAIL row_prewrite: got %h want %h", dbgVal, 64'h33);
    end
    rst = 1'b1; wen = 1'b1; dstE = RCX; valE = 64'h77;
    dstM = RAX; valM = 64'h88;
    tick();
    idle();
    sbq.push_back('{id: RCX, val: 64'h0});
    sbq.push_back('{id: RAX, val: 64'h0});
    sbq.push_back('{id: RBX, val: 64'h0});
    sbq.push_back('{id: RSP, val: c_rsp_init});
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      dbgSel = e.id;
      #1;
      total++;
      if (dbgVal !== e.val) begin
        bad++;
        $display("FAIL row_reg%0d: got %h want %h", e.id, dbgVal, e.val);
      end
    end
  endtask

  task automatic test_bypass();
    logic [63:0] e1, e2;
    idle();
    srcA = RBP; dbgSel = RBP;
    wen  = 1'b1; dstE = RBP; valE = 64'h99;
    #1;
`ifdef Y86_REGFILE_BYPASS_EN
    e1 = 64'h99; e2 = 64'hAA;
`else
    e1 = 64'h0;  e2 = 64'h0;
`endif
    total++;
    if (valA !== e1) begin
      bad++;
      $display("FAIL bypass_e_valA: got %h want %h", valA, e1);
    end
    dstM = RBP; valM = 64'hAA;
    #1;
    total++;
    if (valA !== e2) begin
      bad++;
      $display("FAIL bypass_m_valA: got %h want %h", valA, e2);
    end
    total++;
    if (dbgVal !== 64'h0) begin
      bad++;
      $display("FAIL bypass_dbg_old: got %h want %h", dbgVal, 64'h0);
    end
    tick();
    idle();
    #1;
    total++;
    if (dbgVal !== 64'hAA) begin
      bad++;
      $display("FAIL bypass_after: got %h want %h", dbgVal, 64'hAA);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] pe, pm;
    pe = '0; pm = '0;
    for (int k = 0; k < 7; k++) begin
      logic [63:0] ve, vm;
      ve = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      idle();
      wen  = 1'b1;
      dstE = 4'(k);     valE = ve;
      dstM = 4'(k + 7); valM = vm;
      srcA = 4'(k - 1); srcB = 4'(k + 6);
      sbq.push_back('{id: 4'(k), val: ve});
      sbq.push_back('{id: 4'(k + 7), val: vm});
      #2;
      if (k > 0) begin
        total++;
        if (valA !== pe) begin
          bad++;
          $display("FAIL b2b_vis_valA%0d: got %h want %h", k, valA, pe);
        end
        total++;
        if (valB !== pm) begin
          bad++;
          $display("FAIL b2b_vis_valB%0d: got %h want %h", k, valB, pm);
        end
      end
      pe = ve; pm = vm;
      tick();
    end
    idle();
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      dbgSel = e.id;
      #1;
      total++;
      if (dbgVal !== e.val) begin
        bad++;
        $display("FAIL b2b_reg%0d: got %h want %h", e.id, dbgVal, e.val);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0;
    srcA = RNONE; srcB = RNONE; dbgSel = RNONE;
    dstE = RNONE; dstM = RNONE; valE = '0; valM = '0;
    #1;
    test_reset();
    test_dual_write();
    test_collision();
    test_suppress();
    test_reset_over_write();
    test_bypass();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
